// File: rtl/seven_segment_scanner.sv
// Four-digit time-multiplexed display scanner feeding a seven-segment decoder.
// Each slot has a blank interval, optional leading-zero suppression, per-digit enables and frame-synchronous updates.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_BLANK | slot counter below BLANK_CYCLES, every anode held dark
//   ST_DRIVE | rest of the slot, the current digit's anode lit if enabled
module seven_segment_scanner #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic [3:0]  digit_en,
  output logic [3:0]  nibble,
  output logic [3:0]  anode,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx_nxt;
  logic [15:0]   shadow, active, active_nxt;
  logic          pending;
  logic          boundary, slot_end, in_blank, lit;
  logic [0:0]    state;
  logic [3:0]    sup, anode_nxt;

  // Outputs are registered from next-cycle values so nibble, anode and
  // digit_idx always describe the slot position held in cnt.
  always_comb begin
    slot_end = (cnt == CNT_LAST);
    boundary = slot_end && (digit_idx == 2'd3);
    cnt_nxt  = slot_end ? '0 : cnt + CW'(1);
    idx_nxt  = slot_end ? digit_idx + 2'd1 : digit_idx;
    if (boundary && load)
      active_nxt = value_in;
    else if (boundary && pending)
      active_nxt = shadow;
    else
      active_nxt = active;
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_nxt < CW'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    sup = 4'b0000;
    if (LZ_SUPPRESS != 0) begin
      sup[1] = (active_nxt[15:4]  == 12'h000);
      sup[2] = (active_nxt[15:8]  == 8'h00);
      sup[3] = (active_nxt[15:12] == 4'h0);
    end
    state     = in_blank ? ST_BLANK : ST_DRIVE;
    lit       = digit_en[idx_nxt] & ~sup[idx_nxt];
    anode_nxt = ((state == ST_DRIVE) && lit) ? ~(4'b0001 << idx_nxt) : 4'b1111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      digit_idx  <= 2'd0;
      anode      <= 4'b1111;
      nibble     <= 4'h0;
      shadow     <= 16'h0000;
      active     <= 16'h0000;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      digit_idx  <= idx_nxt;
      anode      <= anode_nxt;
      nibble     <= active_nxt[{idx_nxt, 2'b00} +: 4];
      active     <= active_nxt;
      frame_done <= boundary;
      if (load)
        shadow <= value_in;
      // A load landing on the boundary goes straight to active, so nothing stays pending.
      if (boundary)
        pending <= 1'b0;
      else if (load)
        pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: a cycle model feeds a scoreboard queue, plus a
// vector table of display frames and hand sequences for boundary loads and resets.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  digit_en = 4'b1111;
  logic [3:0]  nibble1, anode1, nibble2, anode2;
  logic [1:0]  idx1, idx2;
  logic        fd1, fd2;

  int n_checks = 0;
  int n_pass   = 0;

  seven_segment_scanner #(.SLOT_CYCLES(8), .BLANK_CYCLES(2), .LZ_SUPPRESS(1)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .digit_en(digit_en),
    .nibble(nibble1), .anode(anode1), .digit_idx(idx1), .frame_done(fd1));

  // No blanking, no suppression
  seven_segment_scanner #(.SLOT_CYCLES(8), .BLANK_CYCLES(0), .LZ_SUPPRESS(0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .load(load), .digit_en(digit_en),
    .nibble(nibble2), .anode(anode2), .digit_idx(idx2), .frame_done(fd2));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  typedef struct packed {
    logic [3:0] an1;
    logic [3:0] nib;
    logic [1:0] idx;
    logic       fd;
    logic [3:0] an2;
  } exp_t;

  exp_t sbq[$];

  int          m_cnt, m_idx;
  logic [15:0] m_act, m_sh;
  logic        m_pend, m_bnd;
  exp_t        m_e;

  // Reference model: one step per rising edge, result queued for the next falling edge.
  initial begin
    m_cnt = 0; m_idx = 0; m_act = 0; m_sh = 0; m_pend = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0; m_idx = 0; m_act = 0; m_sh = 0; m_pend = 0;
        sbq.delete();
      end else begin
        m_bnd = (m_cnt == 7) && (m_idx == 3);
        if (m_bnd) begin
          if (load) begin m_act = value_in; m_sh = value_in; end
          else if (m_pend) m_act = m_sh;
          m_pend = 1'b0;
        end else if (load) begin
          m_sh = value_in; m_pend = 1'b1;
        end
        m_cnt = (m_cnt + 1) % 8;
        if (m_cnt == 0) m_idx = (m_idx + 1) % 4;
        m_e.nib = 4'((m_act >> (4 * m_idx)) & 16'h000F);
        m_e.idx = 2'(m_idx);
        m_e.fd  = m_bnd;
        m_e.an1 = (m_cnt >= 2 && digit_en[m_idx] && (m_idx == 0 || (m_act >> (4 * m_idx)) != 0))
                  ? ~(4'b0001 << m_idx) : 4'b1111;
        m_e.an2 = digit_en[m_idx] ? ~(4'b0001 << m_idx) : 4'b1111;
        sbq.push_back(m_e);
      end
    end
  end

  exp_t sb_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && sbq.size() > 0) begin
        sb_e = sbq.pop_front();
        chk("scan_lz", {5'b0, anode1, nibble1, idx1, fd1}, {5'b0, sb_e.an1, sb_e.nib, sb_e.idx, sb_e.fd});
        chk("scan_nolz", {5'b0, anode2, nibble2, idx2, fd2}, {5'b0, sb_e.an2, sb_e.nib, sb_e.idx, sb_e.fd});
      end
    end
  end

  task automatic wait_fd();
    int n = 0;
    while (!fd1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (!fd1) begin
      n_checks++;
      $display("FAIL wait_frame_done: got timeout expected pulse within 80 cycles at %0t", $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] val;
    logic [3:0]  en;
    logic [15:0] an;   // anode per digit, digit 3 in the top nibble, LZ instance
    logic [15:0] an2;  // same for the no-suppression instance
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h1234, 4'b1111, 16'b0111_1011_1101_1110, 16'b0111_1011_1101_1110};
    vecs[1] = '{16'h0050, 4'b1111, 16'b1111_1111_1101_1110, 16'b0111_1011_1101_1110};
    vecs[2] = '{16'h1234, 4'b1010, 16'b0111_1111_1101_1111, 16'b0111_1111_1101_1111};
    vecs[3] = '{16'h0000, 4'b1111, 16'b1111_1111_1111_1110, 16'b0111_1011_1101_1110};
    vecs[4] = '{16'hABCD, 4'b1111, 16'b0111_1011_1101_1110, 16'b0111_1011_1101_1110};
    vecs[5] = '{16'h0F00, 4'b0111, 16'b1111_1011_1101_1110, 16'b1111_1011_1101_1110};

    // Reset held for five cycles
    repeat (5) begin
      @(negedge clk);
      chk("reset_outputs", {7'b0, anode1, nibble1, fd1}, {7'b0, 4'b1111, 4'h0, 1'b0});
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_blank", {10'b0, anode1, idx1}, {10'b0, 4'b1111, 2'd0});
    repeat (2) @(negedge clk);
    chk("idle_digit0", {8'b0, anode1, nibble1}, {8'b0, 4'b1110, 4'h0});
    repeat (8) @(negedge clk);
    chk("idle_digit1_dark", {12'b0, anode1}, {12'b0, 4'b1111});

    // Frame table
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      value_in = vecs[v].val;
      digit_en = vecs[v].en;
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      wait_fd();
      for (int d = 0; d < 4; d++) begin
        chk("vec_slot_blank", {10'b0, anode1, idx1}, {10'b0, 4'b1111, 2'(d)});
        repeat (4) @(negedge clk);
        chk("vec_nibble", {12'b0, nibble1}, {12'b0, vecs[v].val[4*d +: 4]});
        chk("vec_anode_lz", {12'b0, anode1}, {12'b0, vecs[v].an[4*d +: 4]});
        chk("vec_anode_nolz", {12'b0, anode2}, {12'b0, vecs[v].an2[4*d +: 4]});
        repeat (4) @(negedge clk);
      end
    end

    // Tear-free update: load during digit 1, old value holds until the frame ends
    @(negedge clk);
    value_in = 16'h1234; digit_en = 4'b1111; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    repeat (8) @(negedge clk);
    value_in = 16'hABCD; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (11) @(negedge clk);
    chk("tear_free_d2", {12'b0, nibble1}, {12'b0, 4'h2});
    repeat (8) @(negedge clk);
    chk("tear_free_d3", {12'b0, nibble1}, {12'b0, 4'h1});
    repeat (4) @(negedge clk);
    chk("tear_free_new", {11'b0, fd1, nibble1}, {11'b0, 1'b1, 4'hD});

    // Load on the exact boundary cycle
    repeat (31) @(negedge clk);
    value_in = 16'h5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("coincide_first", {11'b0, fd1, nibble1}, {11'b0, 1'b1, 4'h8});
    repeat (28) @(negedge clk);
    chk("coincide_d3", {10'b0, idx1, nibble1}, {10'b0, 2'd3, 4'h5});

    // Two loads in one frame, the last one wins
    @(negedge clk);
    value_in = 16'h1111; load = 1'b1;
    @(negedge clk);
    value_in = 16'h2222;
    @(negedge clk);
    load = 1'b0;
    wait_fd();
    chk("last_load_wins", {12'b0, nibble1}, {12'b0, 4'h2});

    // Reset mid-DRIVE of digit 2
    begin
      int n = 0;
      while (anode1 != 4'b1011 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("reach_digit2_drive", {12'b0, anode1}, {12'b0, 4'b1011});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_dark", {8'b0, anode1, anode2}, {8'b0, 4'b1111, 4'b1111});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_digit0", {10'b0, idx1, nibble1}, {10'b0, 2'd0, 4'h0});
    repeat (2) @(negedge clk);
    chk("restart_active_zero", {8'b0, anode1, nibble1}, {8'b0, 4'b1110, 4'h0});
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
